// File: rtl/hash160_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : hash160_pkg                                                      |
// | Shared widths, packer state encoding and SHA-256 padding-block builder.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hash160_pkg;

    localparam int unsigned BLK_W  = 512;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        PK_IDLE      = 2'd0,
        PK_FILL      = 2'd1,
        PK_HOLD_DATA = 2'd2,
        PK_HOLD_PAD  = 2'd3
    } packer_state_e;

    // Padding for a message that exactly fills the preceding block.
    function automatic logic [BLK_W-1:0] pad_block(input logic [63:0] len_bits);
        return {8'h80, {(BLK_W-72){1'b0}}, len_bits};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hash_msg_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : hash_msg_packer_if                                             |
// | Byte-input strobe and block valid/ready handshake of the message packer.   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface hash_msg_packer_if;
    import hash160_pkg::*;

    logic              i_valid;
    logic [BYTE_W-1:0] i_text;
    logic              o_in_ready;
    logic              o_blk_valid;
    logic [BLK_W-1:0]  o_blk;
    logic              o_blk_last;
    logic              i_blk_ready;
    logic              o_ovf;

    modport slave (
        input  i_valid, i_text, i_blk_ready,
        output o_in_ready, o_blk_valid, o_blk, o_blk_last, o_ovf
    );

    modport master (
        output i_valid, i_text, i_blk_ready,
        input  o_in_ready, o_blk_valid, o_blk, o_blk_last, o_ovf
    );

endinterface
`default_nettype wire

// File: rtl/hash_msg_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hash_msg_packer                                                  |
// | Packs a 64-byte stream into a 512-bit SHA-256 block; with HASH160_PAD_EN   |
// | defined it follows the data block with the generated padding block.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hash_msg_packer
    import hash160_pkg::*;
#(
    parameter int unsigned MSG_LEN_BITS = 512
) (
    input  wire logic         clk,
    input  wire logic         rst,
    hash_msg_packer_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE      = PK_IDLE;
    localparam logic [1:0] c_ST_FILL      = PK_FILL;
    localparam logic [1:0] c_ST_HOLD_DATA = PK_HOLD_DATA;
`ifdef HASH160_PAD_EN
    localparam logic [1:0]       c_ST_HOLD_PAD = PK_HOLD_PAD;
    localparam logic [BLK_W-1:0] c_PAD_BLK     = pad_block(64'(MSG_LEN_BITS));
`endif

    logic [1:0]       r_state;
    logic [5:0]       r_cnt;
    logic [BLK_W-1:0] r_shift;
    logic             r_ovf;

    logic w_in_ready;
    logic w_blk_valid;
    logic w_xfer;

    assign w_in_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_FILL);
    assign w_blk_valid = !w_in_ready;
    assign w_xfer      = w_blk_valid && bus.i_blk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 6'd0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (bus.i_valid && !w_in_ready) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.i_valid) begin
                        r_shift <= {r_shift[BLK_W-BYTE_W-1:0], bus.i_text};
                        r_cnt   <= 6'd1;
                        r_state <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (bus.i_valid) begin
                        r_shift <= {r_shift[BLK_W-BYTE_W-1:0], bus.i_text};
                        r_cnt   <= r_cnt + 6'd1;
                        if (r_cnt == 6'd63) begin
                            r_state <= c_ST_HOLD_DATA;
                        end
                    end
                end
                c_ST_HOLD_DATA: begin
                    if (w_xfer) begin
`ifdef HASH160_PAD_EN
                        r_state <= c_ST_HOLD_PAD;
`else
                        r_state <= c_ST_IDLE;
`endif
                    end
                end
                default: begin
                    // HOLD_PAD, or an unreachable code in the unpadded build.
                    if (w_xfer) begin
                        r_state <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef HASH160_PAD_EN
    always_comb begin
        bus.o_blk      = r_shift;
        bus.o_blk_last = 1'b0;
        if (r_state == c_ST_HOLD_PAD) begin
            bus.o_blk      = c_PAD_BLK;
            bus.o_blk_last = 1'b1;
        end
    end
`else
    logic w_unused_len;
    assign w_unused_len = ^MSG_LEN_BITS;

    always_comb begin
        bus.o_blk      = r_shift;
        bus.o_blk_last = (r_state == c_ST_HOLD_DATA);
    end
`endif

    assign bus.o_in_ready  = w_in_ready;
    assign bus.o_blk_valid = w_blk_valid;
    assign bus.o_ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/hash_msg_packer.md
# hash_msg_packer

Front-end stage of the Hash160 datapath: it collects the 8-bit byte stream presented on the chip input and assembles it into 512-bit SHA-256 message blocks. It hands those blocks to the SHA-256 compression core over a valid/ready handshake. When compiled with padding, it also generates the SHA-256 padding block for the fixed 64-byte message, so the core only ever sees complete blocks.

## Interface
Parameters:
- MSG_LEN_BITS, 512, message length in bits written into the padding block's length field.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  byte strobe; i_text is sampled when high.
- i_text  input  8  message byte; first byte is the most significant.
- o_in_ready  output  1  high when a byte presented with i_valid is accepted.
- o_blk_valid  output  1  o_blk holds a complete block for the core.
- o_blk  output  512  block data, big-endian; byte 0 of the message is in [511:504].
- o_blk_last  output  1  qualifies o_blk_valid: this is the final block of the message.
- i_blk_ready  input  1  core accepts o_blk this cycle.
- o_ovf  output  1  sticky flag: a byte was presented while o_in_ready was low.

## Operation
- States: IDLE, FILL, HOLD_DATA, HOLD_PAD. HOLD_PAD exists only with padding compiled in.
- IDLE:
  - o_in_ready=1.
  - The first accepted byte goes to FILL, and the byte counter becomes 1.
- FILL:
  - o_in_ready=1.
  - Each accepted byte shifts into the 512-bit register from the LSB end, so after 64 bytes byte 0 sits at [511:504].
  - The counter increments by 1 per byte.
  - Gaps are allowed: while i_valid=0, the counter and the register hold.
  - Accepting the byte with counter=63 moves to HOLD_DATA. The counter wraps to 0.
- HOLD_DATA:
  - o_blk_valid=1 and o_in_ready=0.
  - o_blk is stable until transfer.
  - o_blk_last=0 with padding, 1 without.
- Transfer:
  - A transfer happens on the rising edge where o_blk_valid and i_blk_ready are both high.
  - From HOLD_DATA, a transfer goes to HOLD_PAD with padding, otherwise to IDLE.
  - In HOLD_PAD, o_blk = 0x80 in [511:504], zeros in [503:64], MSG_LEN_BITS in [63:0], and o_blk_last=1.
  - A transfer in HOLD_PAD goes to IDLE.
- i_blk_ready while o_blk_valid=0 is ignored.
- Bytes presented while o_in_ready=0 are dropped and set o_ovf. o_ovf is cleared only by rst.
- Reset values: state IDLE, counter 0, o_blk all zeros, o_blk_valid=0, o_blk_last=0, o_ovf=0, o_in_ready=1.
- Reset mid-operation, in any state: the partial message is discarded and the held block is withdrawn. The block returns to IDLE on the next edge with no block emitted.

## Timing
- Byte k is accepted on edge k, with no gaps.
- o_blk_valid rises in the cycle after the edge that accepted byte 63. Latency is 1 cycle; there is no combinational path from i_text to o_blk.
- With i_blk_ready held high:
  - The data block transfers on the first valid cycle.
  - The padding block is valid in the next cycle and transfers on the following edge.
  - o_in_ready returns high 2 cycles after the data block is first valid.
- o_in_ready is a function of state only. It never depends combinationally on i_blk_ready.
- The back-to-back message rate is bounded by the core's ready; bytes arriving during HOLD are overflow.

## Configuration
- HASH160_PAD_EN defined:
  - The packer emits the data block followed by the generated padding block.
  - o_blk_last is asserted on the padding block only.
- HASH160_PAD_EN undefined:
  - HOLD_PAD and the padding constant are removed.
  - The data block is sent with o_blk_last=1, and the core is responsible for padding.

## Structure
- The shared package hash160_pkg holds:
  - BLK_W=512 and BYTE_W=8.
  - The packer state enum.
  - The padding-block constant function, taking the length and returning a 512-bit value.
- The block is one flat module.
- No sub-module is warranted: the shift register, counter and FSM are each too small to split out.

## Test plan
- Reset, then 64 contiguous bytes 0x00..0x3F with i_blk_ready=1 -> o_blk_valid 1 cycle after the last byte, with o_blk = 0x00010203…3F and o_blk_last=0. The next cycle carries the padding block: 0x80, zeros, then 0x0000000000000200 in [63:0], with o_blk_last=1.
- Same stream with i_valid low for 3 cycles after byte 20 and after byte 50 -> identical o_blk; transfer is delayed by 6 cycles.
- Hold i_blk_ready=0 for 10 cycles after the block is valid -> o_blk stable and o_blk_valid held. The transfer happens on the first ready edge. An extra byte 0xAA presented during the hold sets o_ovf=1 and leaves o_blk unchanged.
- Assert rst after byte 30, then send 64 bytes of 0xFF -> the emitted block is all 0xFF, with no trace of the first partial message. o_ovf=0.
- Without HASH160_PAD_EN, stream 0x00..0x3F -> a single block with o_blk_last=1, then IDLE with o_in_ready=1 on the cycle after transfer.
- Two messages back-to-back, the second starting the cycle o_in_ready rises -> two data+pad block pairs, in order, with no overflow.
